// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Two-requester arbiter and sequencer for a single-port RAM with synchronous
// write and combinational read. Requester A is the CPU datapath, requester B
// is the program loader / debug port. Accesses are serialised with
// round-robin fairness on ties. The RAM address, data and write strobe are
// driven straight from registers. Read data goes back to the winner together
// with a one-cycle ack.
//
// Every transaction walks IDLE -> ACCESS -> ACK, so the arbiter completes at
// most one access every three cycles.
//
// Ports:
//   clk                 system clock, all logic on the rising edge
//   rst_n               asynchronous active-low reset
//   req_a/req_b         access request (level), held until ack is seen
//   we_a/we_b           1 = write, 0 = read
//   addr_a/addr_b       word address
//   wdata_a/wdata_b     write data
//   ack_a/ack_b         one-cycle transaction-complete pulse
//   rdata_a/rdata_b     read data, valid while ack is high, then held
//   ram_addr            RAM address
//   ram_din             RAM write data
//   ram_write           RAM write strobe, high only in ACCESS
//   ram_dout            RAM combinational read data
//   busy                high while in ACCESS or ACK
// ---------------------------------------------------------------------------
module ram_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              req_a,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] wdata_a,
   output logic              ack_a,
   output logic [DATA_W-1:0] rdata_a,

   input  logic              req_b,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              ack_b,
   output logic [DATA_W-1:0] rdata_b,

   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_write,
   input  logic [DATA_W-1:0] ram_dout,

   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_ACK    = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   // Selected requester of the transaction in flight (1 = B).
   logic   r_sel;
   // Winner of the most recent grant (1 = B). Reset to B so A wins the
   // first tie.
   logic   r_last_b;

   logic   w_grant;
   logic   w_grant_b;

   // Next-state and grant decision
   always_comb begin
      w_next    = r_state;
      w_grant   = 1'b0;
      w_grant_b = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (req_a && req_b) begin
               // Tie: hand the RAM to whoever did not have it last time.
               w_grant   = 1'b1;
               w_grant_b = ~r_last_b;
            end else if (req_a) begin
               w_grant   = 1'b1;
               w_grant_b = 1'b0;
            end else if (req_b) begin
               w_grant   = 1'b1;
               w_grant_b = 1'b1;
            end
            if (w_grant) begin
               w_next = S_ACCESS;
            end
         end
         S_ACCESS: w_next = S_ACK;
         S_ACK:    w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Registered outputs: RAM drive, acks, read data and busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_addr  <= '0;
         ram_din   <= '0;
         ram_write <= 1'b0;
         ack_a     <= 1'b0;
         ack_b     <= 1'b0;
         rdata_a   <= '0;
         rdata_b   <= '0;
         busy      <= 1'b0;
         r_sel     <= 1'b0;
         r_last_b  <= 1'b1;
      end else begin
         // busy mirrors the state we are about to enter, so it is high
         // exactly in ACCESS and ACK.
         busy <= (w_next != S_IDLE);

         unique case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  ram_addr  <= w_grant_b ? addr_b  : addr_a;
                  ram_din   <= w_grant_b ? wdata_b : wdata_a;
                  ram_write <= w_grant_b ? we_b    : we_a;
                  r_sel     <= w_grant_b;
                  r_last_b  <= w_grant_b;
               end
            end
            S_ACCESS: begin
               // The RAM commits the write on this same edge, so the
               // captured word is the pre-write contents.
               if (r_sel) begin
                  rdata_b <= ram_dout;
                  ack_b   <= 1'b1;
               end else begin
                  rdata_a <= ram_dout;
                  ack_a   <= 1'b1;
               end
               ram_write <= 1'b0;
            end
            S_ACK: begin
               ack_a <= 1'b0;
               ack_b <= 1'b0;
            end
            default: begin
               ack_a     <= 1'b0;
               ack_b     <= 1'b0;
               ram_write <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;

   logic              clk;
   logic              rst_n;
   logic              req_a, we_a, req_b, we_b;
   logic [ADDR_W-1:0] addr_a, addr_b;
   logic [DATA_W-1:0] wdata_a, wdata_b;
   logic              ack_a, ack_b;
   logic [DATA_W-1:0] rdata_a, rdata_b;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic              ram_write;
   logic [DATA_W-1:0] ram_dout;
   logic              busy;

   int n_vec = 0;
   int n_err = 0;

   // RAM behavioural model: synchronous write, combinational read
   logic [DATA_W-1:0] mem [256] = '{default: 16'h0000};
   // Reference copy of memory contents used to build expectations
   logic [DATA_W-1:0] ref_mem [256] = '{default: 16'h0000};
   // Scoreboard entries: {requester (1=B), expected rdata}
   logic [DATA_W:0]   exp_q [$];

   assign ram_dout = mem[ram_addr];
   always @(posedge clk) begin
      if (ram_write) mem[ram_addr] <= ram_din;
   end

   ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .ack_a(ack_a), .rdata_a(rdata_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .ack_b(ack_b), .rdata_b(rdata_b),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_write(ram_write),
      .ram_dout(ram_dout), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard consumer: every ack pops one expectation
   always @(negedge clk) begin
      logic [DATA_W:0] e;
      logic [DATA_W:0] got;
      if (rst_n && (ack_a || ack_b)) begin
         n_vec++;
         if (ack_a && ack_b) begin
            n_err++;
            $display("FAIL ack_exclusive: ack_a=%b ack_b=%b, required not both 1", ack_a, ack_b);
         end
         got = {ack_b, (ack_b ? rdata_b : rdata_a)};
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: unexpected ack got who=%0d data=%h", got[DATA_W], got[DATA_W-1:0]);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_err++;
               $display("FAIL scoreboard: got who=%0d data=%h, required who=%0d data=%h",
                        got[DATA_W], got[DATA_W-1:0], e[DATA_W], e[DATA_W-1:0]);
            end
         end
      end
   end

   // Push the expected result of one access and update the reference memory
   task automatic expect_txn(input bit who, input bit we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data);
      exp_q.push_back({who, ref_mem[addr]});
      if (we) ref_mem[addr] = data;
   endtask

   // One isolated transaction from IDLE; checks latency and pulse width
   task automatic txn(input bit who, input bit we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] data);
      int lat;
      expect_txn(who, we, addr, data);
      if (who) begin
         req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = data;
      end else begin
         req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = data;
      end
      lat = 0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (who ? ack_b : ack_a) break;
      end
      n_vec++;
      if (lat != 2) begin
         n_err++;
         $display("FAIL txn_latency: who=%0d addr=%h ack after %0d cycles, required 2", who, addr, lat);
      end
      req_a = 1'b0;
      req_b = 1'b0;
      @(negedge clk);
      n_vec++;
      if (ack_a !== 1'b0 || ack_b !== 1'b0) begin
         n_err++;
         $display("FAIL ack_pulse: ack_a=%b ack_b=%b one cycle after ack, required 0 0", ack_a, ack_b);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({ram_addr, ram_din, ram_write, ack_a, ack_b, rdata_a, rdata_b, busy} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: addr=%h din=%h we=%b acks=%b%b rd=%h/%h busy=%b, required all 0",
                  ram_addr, ram_din, ram_write, ack_a, ack_b, rdata_a, rdata_b, busy);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle_busy: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_single_rw;
      txn(1'b0, 1'b1, 8'h3C, 16'hBEEF);
      txn(1'b0, 1'b0, 8'h3C, 16'h0000);
      n_vec++;
      if (rdata_a !== 16'hBEEF) begin
         n_err++;
         $display("FAIL single_rdata_hold: rdata_a=%h, required BEEF", rdata_a);
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      req_a = 1'b1; we_a = 1'b1; addr_a = 8'h77; wdata_a = 16'h1234;
      @(posedge clk);
      #2;
      n_vec++;
      if (ram_write !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL mid_access: ram_write=%b busy=%b, required 1 1", ram_write, busy);
      end
      rst_n = 1'b0;
      req_a = 1'b0;
      #1;
      n_vec++;
      if (ram_write !== 1'b0 || ack_a !== 1'b0 || ack_b !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: ram_write=%b ack_a=%b ack_b=%b busy=%b, required 0 0 0 0",
                  ram_write, ack_a, ack_b, busy);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_vec++;
      if (rdata_a !== 16'h0000 || rdata_b !== 16'h0000 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_rdata: rdata_a=%h rdata_b=%h busy=%b, required 0000 0000 0", rdata_a, rdata_b, busy);
      end
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || ack_a !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release_idle: busy=%b ack_a=%b, required 0 0", busy, ack_a);
      end
   endtask

   task automatic test_read_before_write;
      txn(1'b0, 1'b1, 8'h10, 16'h1111);
      txn(1'b1, 1'b1, 8'h10, 16'h2222);
      n_vec++;
      if (rdata_b !== 16'h1111) begin
         n_err++;
         $display("FAIL rbw_old_data: rdata_b=%h, required 1111", rdata_b);
      end
      txn(1'b1, 1'b0, 8'h10, 16'h0000);
      n_vec++;
      if (rdata_b !== 16'h2222) begin
         n_err++;
         $display("FAIL rbw_new_data: rdata_b=%h, required 2222", rdata_b);
      end
   endtask

   task automatic test_simultaneous;
      int t;
      int k;
      int ack_t [4];
      @(negedge clk);
      rst_n = 1'b0;
      req_a = 1'b1; we_a = 1'b1; addr_a = 8'h40; wdata_a = 16'hA0A0;
      req_b = 1'b1; we_b = 1'b1; addr_b = 8'h41; wdata_b = 16'h0B0B;
      for (int i = 0; i < 2; i++) begin
         expect_txn(1'b0, 1'b1, 8'h40, 16'hA0A0);
         expect_txn(1'b1, 1'b1, 8'h41, 16'h0B0B);
      end
      @(negedge clk);
      rst_n = 1'b1;
      t = 0;
      k = 0;
      while (t < 40 && k < 4) begin
         @(negedge clk);
         t++;
         if (ack_a || ack_b) begin
            ack_t[k] = t;
            k++;
         end
      end
      req_a = 1'b0;
      req_b = 1'b0;
      n_vec++;
      if (k != 4) begin
         n_err++;
         $display("FAIL sim_ack_count: saw %0d acks, required 4", k);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ack_t[i] != 2 + 3 * i) begin
               n_err++;
               $display("FAIL sim_ack_spacing: ack %0d at cycle %0d, required %0d", i, ack_t[i], 2 + 3 * i);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_addr_boundary;
      txn(1'b0, 1'b1, 8'h00, 16'h0001);
      txn(1'b0, 1'b1, 8'hFF, 16'hFFFF);
      txn(1'b0, 1'b0, 8'h00, 16'h0000);
      n_vec++;
      if (rdata_a !== 16'h0001) begin
         n_err++;
         $display("FAIL boundary_lo: rdata_a=%h, required 0001", rdata_a);
      end
      txn(1'b0, 1'b0, 8'hFF, 16'h0000);
      n_vec++;
      if (rdata_a !== 16'hFFFF) begin
         n_err++;
         $display("FAIL boundary_hi: rdata_a=%h, required FFFF", rdata_a);
      end
   endtask

   task automatic test_back_to_back;
      int t;
      int k;
      int prev;
      int low;
      req_a = 1'b1; we_a = 1'b0; addr_a = 8'h3C; wdata_a = 16'h0000;
      for (int i = 0; i < 3; i++) expect_txn(1'b0, 1'b0, 8'h3C, 16'h0000);
      t = 0; k = 0; prev = 0; low = 0;
      while (t < 40 && k < 3) begin
         @(negedge clk);
         t++;
         if (!busy) low++;
         if (ack_a) begin
            if (k > 0) begin
               n_vec++;
               if (t - prev != 3 || low != 1) begin
                  n_err++;
                  $display("FAIL b2b_spacing: ack %0d gap=%0d idle_cycles=%0d, required 3 and 1", k, t - prev, low);
               end
            end
            prev = t;
            low = 0;
            k++;
         end
      end
      req_a = 1'b0;
      n_vec++;
      if (k != 3) begin
         n_err++;
         $display("FAIL b2b_ack_count: saw %0d acks, required 3", k);
      end
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_return_idle: busy=%b, required 0", busy);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
      req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
      test_reset();
      test_single_rw();
      test_reset_mid();
      test_read_before_write();
      test_simultaneous();
      test_addr_boundary();
      test_back_to_back();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_leftover: %0d expectations not consumed, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
